operand_forward_ctrl: RTL and testbench

- Pipeline hazard and forwarding controller for the 32-bit core.
- Sits directly upstream of the EX-stage operand multiplexers. It drives the 2-bit select of the 4-to-1 operand-A and operand-B muxes:
  - 00 = register file
  - 01 = EX/MEM result
  - 10 = MEM/WB result
  - 11 = immediate (operand B only)
- Tracks destination info of in-flight instructions in a shadow pipeline, detects load-use hazards, inserts bubbles and counts stall cycles.

---
 rtl/operand_forward_ctrl_if.sv | 35 +++
 rtl/operand_forward_ctrl.sv | 105 ++++++++++
 tb/tb_operand_forward_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/operand_forward_ctrl_if.sv
// Decode-side handshake and EX operand-select bundle for operand_forward_ctrl.
// master = decode/test driver, slave = the forwarding controller.
interface operand_forward_ctrl_if #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_rs1_en;
  logic                  id_rs2_en;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic                  id_imm_b;
  logic                  hold;
  logic                  id_ready;
  logic                  stall;
  logic                  ex_valid;
  logic [1:0]            ex_fwd_a_sel;
  logic [1:0]            ex_fwd_b_sel;
  logic [CNT_W-1:0]      stall_count;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_en, id_rs2_en, id_rd,
           id_reg_write, id_mem_read, id_imm_b, hold,
    input  id_ready, stall, ex_valid, ex_fwd_a_sel, ex_fwd_b_sel, stall_count
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_en, id_rs2_en, id_rd,
           id_reg_write, id_mem_read, id_imm_b, hold,
    output id_ready, stall, ex_valid, ex_fwd_a_sel, ex_fwd_b_sel, stall_count
  );
endinterface

// File: rtl/operand_forward_ctrl.sv
// EX-stage operand forwarding and load-use hazard controller.
// Tracks in-flight destinations, selects operand mux sources, inserts bubbles, counts stalls.
module operand_forward_ctrl #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  operand_forward_ctrl_if.slave bus
);

  localparam logic [1:0] SelRf  = 2'b00;
  localparam logic [1:0] SelMem = 2'b01;  // EX/MEM result
  localparam logic [1:0] SelWb  = 2'b10;  // MEM/WB result
  localparam logic [1:0] SelImm = 2'b11;

  // EX and MEM shadow slots. The WB slot is never forwarded from (write-before-read
  // register file) and nothing reads it, so it is not materialised.
  logic                  r_ex_valid;
  logic [REG_ADDR_W-1:0] r_ex_rd;
  logic                  r_ex_rw;
  logic                  r_ex_mr;
  logic                  r_mem_valid;
  logic [REG_ADDR_W-1:0] r_mem_rd;
  logic                  r_mem_rw;
  logic [1:0]            r_sel_a;
  logic [1:0]            r_sel_b;
  logic [CNT_W-1:0]      r_cnt;

  logic       w_ex_hit_rs1;
  logic       w_ex_hit_rs2;
  logic       w_mem_hit_rs1;
  logic       w_mem_hit_rs2;
  logic       w_stall;
  logic [1:0] w_sel_a;
  logic [1:0] w_sel_b;

  always_comb begin
    w_ex_hit_rs1  = r_ex_valid & r_ex_rw & (r_ex_rd == bus.id_rs1) &
                    (bus.id_rs1 != '0) & bus.id_rs1_en;
    w_ex_hit_rs2  = r_ex_valid & r_ex_rw & (r_ex_rd == bus.id_rs2) &
                    (bus.id_rs2 != '0) & bus.id_rs2_en;
    w_mem_hit_rs1 = r_mem_valid & r_mem_rw & (r_mem_rd == bus.id_rs1) &
                    (bus.id_rs1 != '0) & bus.id_rs1_en;
    w_mem_hit_rs2 = r_mem_valid & r_mem_rw & (r_mem_rd == bus.id_rs2) &
                    (bus.id_rs2 != '0) & bus.id_rs2_en;

    // An immediate operand B never waits on rs2.
    w_stall = rst_n & bus.id_valid & ~bus.hold & r_ex_mr &
              (w_ex_hit_rs1 | (w_ex_hit_rs2 & ~bus.id_imm_b));

    w_sel_a = SelRf;
    w_sel_b = SelRf;
    if (bus.id_valid) begin
      if (w_ex_hit_rs1)       w_sel_a = SelMem;
      else if (w_mem_hit_rs1) w_sel_a = SelWb;

      if (bus.id_imm_b)       w_sel_b = SelImm;
      else if (w_ex_hit_rs2)  w_sel_b = SelMem;
      else if (w_mem_hit_rs2) w_sel_b = SelWb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid  <= 1'b0;
      r_ex_rd     <= '0;
      r_ex_rw     <= 1'b0;
      r_ex_mr     <= 1'b0;
      r_mem_valid <= 1'b0;
      r_mem_rd    <= '0;
      r_mem_rw    <= 1'b0;
      r_sel_a     <= SelRf;
      r_sel_b     <= SelRf;
      r_cnt       <= '0;
    end else if (!bus.hold) begin
      r_mem_valid <= r_ex_valid;
      r_mem_rd    <= r_ex_rd;
      r_mem_rw    <= r_ex_rw;
      if (w_stall) begin
        r_ex_valid <= 1'b0;
        r_ex_rw    <= 1'b0;
        r_ex_mr    <= 1'b0;
        r_sel_a    <= SelRf;
        r_sel_b    <= SelRf;
        if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_ex_valid <= bus.id_valid;
        r_ex_rd    <= bus.id_rd;
        r_ex_rw    <= bus.id_reg_write;
        r_ex_mr    <= bus.id_mem_read;
        r_sel_a    <= w_sel_a;
        r_sel_b    <= w_sel_b;
      end
    end
  end

  assign bus.stall        = w_stall;
  assign bus.id_ready     = rst_n & ~bus.hold & ~w_stall;
  assign bus.ex_valid     = r_ex_valid;
  assign bus.ex_fwd_a_sel = r_sel_a;
  assign bus.ex_fwd_b_sel = r_sel_b;
  assign bus.stall_count  = r_cnt;

endmodule

// File: tb/tb_operand_forward_ctrl.sv
// Table-driven bench for operand_forward_ctrl; a second instance with a 2-bit counter
// shares the stimulus to exercise counter saturation.
module tb_operand_forward_ctrl;

  localparam int unsigned AW = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  operand_forward_ctrl_if #(.REG_ADDR_W(AW), .CNT_W(16)) bus ();
  operand_forward_ctrl_if #(.REG_ADDR_W(AW), .CNT_W(2))  bus_s ();

  assign bus_s.id_valid     = bus.id_valid;
  assign bus_s.id_rs1       = bus.id_rs1;
  assign bus_s.id_rs2       = bus.id_rs2;
  assign bus_s.id_rs1_en    = bus.id_rs1_en;
  assign bus_s.id_rs2_en    = bus.id_rs2_en;
  assign bus_s.id_rd        = bus.id_rd;
  assign bus_s.id_reg_write = bus.id_reg_write;
  assign bus_s.id_mem_read  = bus.id_mem_read;
  assign bus_s.id_imm_b     = bus.id_imm_b;
  assign bus_s.hold         = bus.hold;

  operand_forward_ctrl #(.REG_ADDR_W(AW), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  operand_forward_ctrl #(.REG_ADDR_W(AW), .CNT_W(2)) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s)
  );

  typedef struct {
    logic          valid;
    logic [AW-1:0] rs1;
    logic          rs1_en;
    logic [AW-1:0] rs2;
    logic          rs2_en;
    logic [AW-1:0] rd;
    logic          rw;
    logic          mr;
    logic          imm;
    logic          hold;
    logic          exp_stall;
    logic          exp_ready;
    logic          exp_exv;
    logic [1:0]    exp_a;
    logic [1:0]    exp_b;
    int            exp_cnt;
  } vec_t;

  typedef struct {
    logic       exv;
    logic [1:0] a;
    logic [1:0] b;
    int         cnt;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(input logic v, input int rs1, input logic e1, input int rs2,
                              input logic e2, input int rd, input logic rw, input logic mr,
                              input logic imm, input logic hold, input logic st,
                              input logic rdy, input logic exv, input int a, input int b,
                              input int cnt);
    vec_t t;
    t.valid = v;        t.rs1 = AW'(rs1);  t.rs1_en = e1;
    t.rs2 = AW'(rs2);   t.rs2_en = e2;     t.rd = AW'(rd);
    t.rw = rw;          t.mr = mr;         t.imm = imm;      t.hold = hold;
    t.exp_stall = st;   t.exp_ready = rdy; t.exp_exv = exv;
    t.exp_a = 2'(a);    t.exp_b = 2'(b);   t.exp_cnt = cnt;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.id_valid     = v.valid;
    bus.id_rs1       = v.rs1;
    bus.id_rs1_en    = v.rs1_en;
    bus.id_rs2       = v.rs2;
    bus.id_rs2_en    = v.rs2_en;
    bus.id_rd        = v.rd;
    bus.id_reg_write = v.rw;
    bus.id_mem_read  = v.mr;
    bus.id_imm_b     = v.imm;
    bus.hold         = v.hold;
  endtask

  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    drive(v);
    #1;
    chk($sformatf("v%0d stall", idx), 32'(bus.stall), 32'(v.exp_stall));
    chk($sformatf("v%0d id_ready", idx), 32'(bus.id_ready), 32'(v.exp_ready));
    sb.push_back('{exv: v.exp_exv, a: v.exp_a, b: v.exp_b, cnt: v.exp_cnt});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk($sformatf("v%0d ex_valid", idx), 32'(bus.ex_valid), 32'(e.exv));
    chk($sformatf("v%0d fwd_a", idx), 32'(bus.ex_fwd_a_sel), 32'(e.a));
    chk($sformatf("v%0d fwd_b", idx), 32'(bus.ex_fwd_b_sel), 32'(e.b));
    chk($sformatf("v%0d stall_count", idx), 32'(bus.stall_count), 32'(e.cnt));
    chk($sformatf("v%0d sat_count", idx), 32'(bus_s.stall_count),
        32'((e.cnt > 3) ? 3 : e.cnt));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //            v rs1 e rs2 e rd rw mr im ho  st rdy exv a b cnt
    vecs.push_back(mk(1, 1, 1, 2, 1, 5, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0)); // writes r5
    vecs.push_back(mk(1, 5, 1, 6, 1, 8, 1, 0, 0, 0, 0, 1, 1, 1, 0, 0)); // rs1=r5 from EX
    vecs.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0)); // writes r7
    vecs.push_back(mk(1, 1, 1, 2, 1, 10, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 7, 1, 11, 1, 0, 0, 0, 0, 1, 1, 0, 2, 0)); // rs2=r7 from MEM
    vecs.push_back(mk(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 9, 1, 9, 1, 12, 1, 0, 1, 0, 0, 1, 1, 1, 3, 0)); // EX beats MEM, imm
    vecs.push_back(mk(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0)); // load r3
    vecs.push_back(mk(1, 3, 1, 4, 1, 13, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1)); // load-use bubble
    vecs.push_back(mk(1, 3, 1, 4, 1, 13, 1, 0, 0, 0, 0, 1, 1, 2, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 1)); // load r0
    vecs.push_back(mk(1, 0, 1, 0, 1, 14, 1, 0, 0, 0, 0, 1, 1, 0, 0, 1)); // x0 ignored
    vecs.push_back(mk(1, 0, 0, 0, 0, 6, 1, 1, 0, 0, 0, 1, 1, 0, 0, 1)); // load r6
    vecs.push_back(mk(1, 1, 1, 6, 1, 15, 1, 0, 1, 0, 0, 1, 1, 0, 3, 1)); // imm masks rs2
    vecs.push_back(mk(1, 0, 0, 0, 0, 20, 1, 1, 0, 0, 0, 1, 1, 0, 0, 1)); // load r20
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1, 20, 1, 15, 1, 21, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1)); // held
    vecs.push_back(mk(1, 20, 1, 15, 1, 21, 1, 0, 0, 0, 1, 0, 0, 0, 0, 2));
    vecs.push_back(mk(1, 20, 1, 15, 1, 21, 1, 0, 0, 0, 0, 1, 1, 2, 0, 2)); // r15 in WB: rf
    vecs.push_back(mk(0, 21, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2)); // no instruction
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 0, 0, 2));
    vecs.push_back(mk(1, 0, 0, 1, 1, 2, 1, 0, 0, 0, 1, 0, 0, 0, 0, 3));
    vecs.push_back(mk(1, 0, 0, 1, 1, 2, 1, 0, 0, 0, 0, 1, 1, 0, 2, 3));
    vecs.push_back(mk(1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 0, 1, 1, 0, 0, 3));
    vecs.push_back(mk(1, 4, 1, 0, 0, 5, 1, 0, 0, 0, 1, 0, 0, 0, 0, 4));
    vecs.push_back(mk(1, 4, 1, 0, 0, 5, 1, 0, 0, 0, 0, 1, 1, 2, 0, 4));
    vecs.push_back(mk(1, 0, 0, 0, 0, 8, 1, 1, 0, 0, 0, 1, 1, 0, 0, 4));
    vecs.push_back(mk(1, 8, 1, 0, 0, 9, 1, 0, 0, 0, 1, 0, 0, 0, 0, 5));
    vecs.push_back(mk(1, 8, 1, 0, 0, 9, 1, 0, 0, 0, 0, 1, 1, 2, 0, 5));

    drive(mk(1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    chk("reset ex_valid", 32'(bus.ex_valid), 32'd0);
    chk("reset fwd_a", 32'(bus.ex_fwd_a_sel), 32'd0);
    chk("reset fwd_b", 32'(bus.ex_fwd_b_sel), 32'd0);
    chk("reset stall_count", 32'(bus.stall_count), 32'd0);
    chk("reset id_ready", 32'(bus.id_ready), 32'd0);
    chk("reset stall", 32'(bus.stall), 32'd0);
    @(negedge clk);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Asynchronous reset mid-stream: EX currently holds a forwarded reader.
    drive(mk(1, 9, 1, 9, 1, 10, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b0;
    #1;
    chk("midrst ex_valid", 32'(bus.ex_valid), 32'd0);
    chk("midrst fwd_a", 32'(bus.ex_fwd_a_sel), 32'd0);
    chk("midrst fwd_b", 32'(bus.ex_fwd_b_sel), 32'd0);
    chk("midrst stall_count", 32'(bus.stall_count), 32'd0);
    chk("midrst sat_count", 32'(bus_s.stall_count), 32'd0);
    chk("midrst id_ready", 32'(bus.id_ready), 32'd0);
    chk("midrst stall", 32'(bus.stall), 32'd0);
    #3;
    rst_n = 1'b1;
    // Nothing in flight survives: a reader of r9 gets the register file.
    apply(mk(1, 9, 1, 9, 1, 10, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0), 99);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
